// File: rtl/rice_bus_pkg.sv
// Shared types and helpers for the rice bus arbiter: grant-lock state and
// round-robin index arithmetic.
package rice_bus_pkg;

   typedef enum logic {
      GRANT_OPEN   = 1'b0,
      GRANT_LOCKED = 1'b1
   } grant_state_e;

   // Successor of idx in a ring of n requesters.
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rice_bus_arbiter_id_fifo.sv
// Synchronous FIFO of master IDs recording the order in which requests were
// accepted, so responses can be routed back in order.
module rice_bus_arbiter_id_fifo
   import rice_bus_pkg::*;
#(
   parameter int ID_WIDTH = 1,
   parameter int DEPTH    = 4
) (
   input  logic                clk,
   input  logic                srst,
   input  logic                push,
   input  logic [ID_WIDTH-1:0] push_id,
   input  logic                pop,
   output logic [ID_WIDTH-1:0] head_id,
   output logic                full,
   output logic                empty
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [ID_WIDTH-1:0] mem_reg [DEPTH];
   logic [PTR_W-1:0]    wr_ptr_reg;
   logic [PTR_W-1:0]    rd_ptr_reg;
   logic [PTR_W:0]      count_reg;
   logic                push_ok;
   logic                pop_ok;

   assign full    = (count_reg == (PTR_W+1)'(DEPTH));
   assign empty   = (count_reg == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign head_id = mem_reg[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_reg[wr_ptr_reg] <= push_id;
      end
   end

   // Depth is a power of two, so the pointers wrap by natural overflow.
   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   a_count_bound: assert property (@(posedge clk) disable iff (srst)
      count_reg <= (PTR_W+1)'(DEPTH));

endmodule

// File: rtl/rice_bus_arbiter.sv
// Round-robin arbiter sharing one memory-side rice bus among N requesters;
// grants lock until accepted and responses return in acceptance order.
module rice_bus_arbiter
   import rice_bus_pkg::*;
#(
   parameter int N_MASTERS       = 2,
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                              i_clk,
   input  logic                              i_rst,
   input  logic [N_MASTERS-1:0]              i_m_request_valid,
   output logic [N_MASTERS-1:0]              o_m_request_ready,
   input  logic [N_MASTERS*ADDR_WIDTH-1:0]   i_m_address,
   input  logic [N_MASTERS-1:0]              i_m_write,
   input  logic [N_MASTERS*DATA_WIDTH-1:0]   i_m_write_data,
   input  logic [N_MASTERS*DATA_WIDTH/8-1:0] i_m_strobe,
   output logic [N_MASTERS-1:0]              o_m_response_valid,
   input  logic [N_MASTERS-1:0]              i_m_response_ready,
   output logic [N_MASTERS*DATA_WIDTH-1:0]   o_m_read_data,
   output logic [N_MASTERS-1:0]              o_m_error,
   output logic                              o_s_request_valid,
   input  logic                              i_s_request_ready,
   output logic [ADDR_WIDTH-1:0]             o_s_address,
   output logic                              o_s_write,
   output logic [DATA_WIDTH-1:0]             o_s_write_data,
   output logic [DATA_WIDTH/8-1:0]           o_s_strobe,
   input  logic                              i_s_response_valid,
   output logic                              o_s_response_ready,
   input  logic [DATA_WIDTH-1:0]             i_s_read_data,
   input  logic                              i_s_error
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int ID_WIDTH   = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

   typedef logic [ID_WIDTH-1:0] id_t;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] address;
      logic                  write;
      logic [DATA_WIDTH-1:0] write_data;
      logic [STRB_WIDTH-1:0] strobe;
   } request_t;

   request_t     req [N_MASTERS];
   request_t     s_payload;
   grant_state_e lock_state_reg;
   id_t          lock_id_reg;
   id_t          prio_reg;
   id_t          grant_id;
   id_t          scan_id;
   id_t          head_id;
   logic         grant_found;
   logic         grant_valid;
   logic         accept;
   logic         fifo_full;
   logic         fifo_empty;
   logic         resp_route;
   logic         resp_pop;
   int unsigned  scan_idx;

   for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_master
      assign req[gi].address    = i_m_address[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign req[gi].write      = i_m_write[gi];
      assign req[gi].write_data = i_m_write_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign req[gi].strobe     = i_m_strobe[gi*STRB_WIDTH +: STRB_WIDTH];

      assign o_m_request_ready[gi]  = accept & (grant_id == id_t'(gi));
      assign o_m_response_valid[gi] = resp_route & i_s_response_valid & (head_id == id_t'(gi));
      assign o_m_read_data[gi*DATA_WIDTH +: DATA_WIDTH] = i_s_read_data;
      assign o_m_error[gi] = i_s_error;
   end

   // A locked grant bypasses the scan; otherwise pick the first valid
   // requester at or after the priority pointer.
   always_comb begin
      grant_id    = lock_id_reg;
      grant_found = 1'b0;
      scan_idx    = 0;
      scan_id     = '0;
      if (lock_state_reg == GRANT_LOCKED) begin
         grant_found = 1'b1;
      end else begin
         for (int unsigned k = 0; k < N_MASTERS; k++) begin
            scan_idx = (32'(prio_reg) + k) % 32'(N_MASTERS);
            scan_id  = id_t'(scan_idx);
            if (!grant_found && i_m_request_valid[scan_id]) begin
               grant_found = 1'b1;
               grant_id    = scan_id;
            end
         end
      end
   end

   assign grant_valid       = grant_found & i_m_request_valid[grant_id];
   assign s_payload         = req[grant_id];
   assign o_s_request_valid = grant_valid & ~fifo_full & ~i_rst;
   assign accept            = o_s_request_valid & i_s_request_ready;
   assign o_s_address       = s_payload.address;
   assign o_s_write         = s_payload.write;
   assign o_s_write_data    = s_payload.write_data;
   assign o_s_strobe        = s_payload.strobe;

   assign resp_route         = ~fifo_empty & ~i_rst;
   assign o_s_response_ready = resp_route & i_m_response_ready[head_id];
   assign resp_pop           = i_s_response_valid & o_s_response_ready;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         lock_state_reg <= GRANT_OPEN;
         lock_id_reg    <= '0;
         prio_reg       <= '0;
      end else if (accept) begin
         lock_state_reg <= GRANT_OPEN;
         prio_reg       <= id_t'(rr_next(32'(grant_id), 32'(N_MASTERS)));
      end else if (grant_valid) begin
         lock_state_reg <= GRANT_LOCKED;
         lock_id_reg    <= grant_id;
      end
   end

   rice_bus_arbiter_id_fifo #(
      .ID_WIDTH (ID_WIDTH),
      .DEPTH    (MAX_OUTSTANDING)
   ) u_id_fifo (
      .clk     (i_clk),
      .srst    (i_rst),
      .push    (accept),
      .push_id (grant_id),
      .pop     (resp_pop),
      .head_id (head_id),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   a_payload_stable: assert property (@(posedge i_clk) disable iff (i_rst)
      (lock_state_reg == GRANT_LOCKED) |-> $stable(s_payload));

   a_no_orphan_response: assert property (@(posedge i_clk) disable iff (i_rst)
      i_s_response_valid |-> !fifo_empty);

endmodule
